// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC read sequencer: register table, FSM states,
// bus strobe bundles and parameter defaults.
package rtc_pkg;

  localparam int T_FASE_DEF    = 4;
  localparam int N_RELLENO_DEF = 4;
  localparam int N_DATOS_DEF   = 11;
  localparam int N_DIR         = 11;

  // RTC register addresses in read order; entry 0 is the LSB slot.
  // s, min, h, date, month, year, weekday, week no., timer s/min/h
  localparam logic [N_DIR-1:0][7:0] DIR_TABLE = {
    8'h43, 8'h42, 8'h41, 8'h28, 8'h27, 8'h26,
    8'h25, 8'h24, 8'h23, 8'h22, 8'h21
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_READ,
    ST_NEXT,
    ST_WAIT_WIN,
    ST_STREAM
  } estado_t;

  // Bus control bundle, all strobes active-low; oe = block drives ad_out.
  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic a_d;
    logic oe;
  } bus_ctl_t;

  localparam bus_ctl_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a_d: 1'b0, oe: 1'b0};
  localparam bus_ctl_t BUS_ADDR = '{cs_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, a_d: 1'b0, oe: 1'b1};
  localparam bus_ctl_t BUS_READ = '{cs_n: 1'b0, rd_n: 1'b0, wr_n: 1'b1, a_d: 1'b1, oe: 1'b0};

  // Address of the idx-th register; indexes past the table read as 0.
  function automatic logic [7:0] dir_addr(input logic [3:0] idx);
    return (idx < 4'(N_DIR)) ? DIR_TABLE[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/conv_bcd_bin.sv
// Packed two-digit BCD to binary; any nibble above 9 yields 8'hFF.
module conv_bcd_bin (
  input  logic [7:0] bcd,
  output logic [7:0] bin
);

  logic [3:0] hi;
  logic [3:0] lo;

  assign hi = bcd[7:4];
  assign lo = bcd[3:0];

  // tens*10 built as tens*8 + tens*2 plus units
  always_comb begin
    if (hi > 4'd9 || lo > 4'd9) bin = 8'hFF;
    else                        bin = {1'b0, hi, 3'b000} + {3'b000, hi, 1'b0} + {4'h0, lo};
  end

endmodule

// File: rtl/lectura_rtc.sv
// Reads N_DATOS RTC registers over the multiplexed bus, converts each from
// BCD, and streams them (after N_RELLENO zero pad bytes) during vblank.
module lectura_rtc
  import rtc_pkg::*;
#(
  parameter int T_FASE    = T_FASE_DEF,
  parameter int N_RELLENO = N_RELLENO_DEF,
  parameter int N_DATOS   = N_DATOS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       leer,
  input  logic       ventana,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] datoRTC,
  output logic       inicioSecuencia,
  output logic       ocupado
);

  localparam int IDX_W   = (N_DATOS > 1) ? $clog2(N_DATOS) : 1;
  localparam int N_BURST = N_RELLENO + N_DATOS;
  localparam int CNT_MAX = (T_FASE > N_BURST) ? T_FASE : N_BURST;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FASE_LAST  = CNT_W'(T_FASE - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(N_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DATOS - 1);

  estado_t                   st;
  logic [CNT_W-1:0]          cnt;      // bus phase cycle, or burst position in STREAM
  logic [IDX_W-1:0]          idx;      // register being read
  logic [7:0]                rd_q;     // raw BCD captured at the end of READ
  logic [N_DATOS-1:0][7:0]   buf_q;    // converted values, persist across sequences
  bus_ctl_t                  bus_q;
  logic [7:0]                bin;
  logic [CNT_W-1:0]          k_nxt;
  logic [7:0]                byte_nxt;

  assign cs_n  = bus_q.cs_n;
  assign rd_n  = bus_q.rd_n;
  assign wr_n  = bus_q.wr_n;
  assign a_d   = bus_q.a_d;
  assign ad_oe = bus_q.oe;

  conv_bcd_bin u_conv (
    .bcd (rd_q),
    .bin (bin)
  );

  // Burst byte for the next STREAM cycle: position 0 on entry, else cnt+1
  always_comb begin
    k_nxt    = (st == ST_STREAM) ? cnt + CNT_W'(1) : '0;
    byte_nxt = 8'h00;
    if (k_nxt >= CNT_W'(N_RELLENO) && k_nxt < CNT_W'(N_BURST))
      byte_nxt = buf_q[IDX_W'(k_nxt - CNT_W'(N_RELLENO))];
  end

  // Sequencer FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st              <= ST_IDLE;
      cnt             <= '0;
      idx             <= '0;
      rd_q            <= '0;
      buf_q           <= '0;
      bus_q           <= BUS_IDLE;
      ad_out          <= '0;
      datoRTC         <= '0;
      inicioSecuencia <= 1'b0;
      ocupado         <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (leer) begin
            st      <= ST_ADDR;
            idx     <= '0;
            cnt     <= '0;
            bus_q   <= BUS_ADDR;
            ad_out  <= dir_addr(4'd0);
            ocupado <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (cnt == FASE_LAST) begin
            st     <= ST_READ;
            cnt    <= '0;
            bus_q  <= BUS_READ;
            ad_out <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_READ: begin
          // data is only trusted once the RTC has had the whole phase
          if (cnt == FASE_LAST) begin
            st    <= ST_NEXT;
            cnt   <= '0;
            rd_q  <= ad_in;
            bus_q <= BUS_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_NEXT: begin
          buf_q[idx] <= bin;
          if (idx == IDX_LAST) begin
            st <= ST_WAIT_WIN;
          end else begin
            st     <= ST_ADDR;
            idx    <= idx + IDX_W'(1);
            bus_q  <= BUS_ADDR;
            ad_out <= dir_addr(4'(idx + IDX_W'(1)));
          end
        end
        ST_WAIT_WIN: begin
          if (ventana) begin
            st              <= ST_STREAM;
            cnt             <= '0;
            inicioSecuencia <= 1'b1;
            datoRTC         <= byte_nxt;
          end
        end
        ST_STREAM: begin
          // ventana is ignored here: a started burst always runs to the end
          if (cnt == BURST_LAST) begin
            st              <= ST_IDLE;
            cnt             <= '0;
            inicioSecuencia <= 1'b0;
            datoRTC         <= 8'h00;
            ocupado         <= 1'b0;
          end else begin
            cnt     <= k_nxt;
            datoRTC <= byte_nxt;
          end
        end
        default: begin
          st              <= ST_IDLE;
          cnt             <= '0;
          bus_q           <= BUS_IDLE;
          ad_out          <= '0;
          datoRTC         <= '0;
          inicioSecuencia <= 1'b0;
          ocupado         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lectura_rtc.sv
// Bench for lectura_rtc: a bus-level RTC model answers reads, and a register
// file level model predicts the burst contents and timing.
module tb_lectura_rtc;

  localparam int T_FASE = 4;
  localparam int N_R    = 4;
  localparam int N_D    = 11;
  localparam int N_B    = N_R + N_D;
  localparam int T_SEQ  = N_D * (2 * T_FASE + 1);   // ADDR entry to WAIT_WIN

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       leer = 1'b0;
  logic       ventana = 1'b0;
  logic [7:0] ad_in = 8'hEE;
  logic [7:0] ad_out;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d;
  logic [7:0] datoRTC;
  logic       inicioSecuencia, ocupado;

  always #5 clk = ~clk;

  lectura_rtc #(.T_FASE(T_FASE), .N_RELLENO(N_R), .N_DATOS(N_D)) dut (
    .clk             (clk),
    .reset           (reset),
    .leer            (leer),
    .ventana         (ventana),
    .ad_in           (ad_in),
    .ad_out          (ad_out),
    .ad_oe           (ad_oe),
    .cs_n            (cs_n),
    .rd_n            (rd_n),
    .wr_n            (wr_n),
    .a_d             (a_d),
    .datoRTC         (datoRTC),
    .inicioSecuencia (inicioSecuencia),
    .ocupado         (ocupado)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rtc_mem [256];
  logic [7:0] mdl_buf [N_D];
  logic [7:0] tb_dir  [N_D] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                8'h27, 8'h28, 8'h41, 8'h42, 8'h43};

  // observations of the last run_seq
  logic [7:0] burst [$];
  int         runs  [$];
  logic [7:0] addrs [$];
  int         t_cs0, t_ini0, t_done, bad_out, restarts;
  bit         done;

  function automatic logic [7:0] bcd2bin(input logic [7:0] v);
    int hi, lo;
    hi = int'(v) / 16;
    lo = int'(v) % 16;
    if (hi > 9 || lo > 9) return 8'hFF;
    return 8'(hi * 10 + lo);
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    return (k < N_R) ? 8'h00 : mdl_buf[k - N_R];
  endfunction

  task automatic model_update();
    for (int j = 0; j < N_D; j++) mdl_buf[j] = bcd2bin(rtc_mem[tb_dir[j]]);
  endtask

  task automatic fill_random();
    int d;
    for (int a = 0; a < 256; a++) begin
      d = $urandom_range(0, 99);
      if ($urandom_range(0, 4) == 0) rtc_mem[a] = 8'($urandom_range(0, 255));
      else                           rtc_mem[a] = 8'(((d / 10) << 4) | (d % 10));
    end
  endtask

  // Pulse leer, then watch every cycle while acting as the RTC. Cycle c is
  // the sample after the c-th edge following the leer pulse (c=0: ADDR entry).
  task automatic run_seq(input int ven_on, input int ven_off, input int leer2_at, input int max_cyc);
    int run_len;
    bit prev_oe, seen;
    logic [7:0] lat;
    burst.delete(); runs.delete(); addrs.delete();
    t_cs0 = -1; t_ini0 = -1; t_done = -1; bad_out = 0; restarts = 0; done = 0;
    run_len = 0; prev_oe = 0; seen = 0; lat = 8'h00;
    @(negedge clk); leer = 1'b1; ventana = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (!cs_n && t_cs0 < 0) t_cs0 = c;
      if (!cs_n) run_len++;
      else if (run_len > 0) begin runs.push_back(run_len); run_len = 0; end
      if (ad_oe && !prev_oe) addrs.push_back(ad_out);
      prev_oe = ad_oe;
      if (ad_oe && (cs_n || wr_n || !rd_n || a_d)) bad_out++;
      if (!rd_n && (cs_n || !wr_n || !a_d || ad_oe)) bad_out++;
      if (inicioSecuencia) begin
        if (t_ini0 < 0) t_ini0 = c;
        burst.push_back(datoRTC);
      end else if (datoRTC !== 8'h00) bad_out++;
      if (ocupado) begin
        seen = 1;
        if (done) restarts++;
      end else if (seen && !done) begin
        done = 1; t_done = c;
      end
      if (ad_oe && !wr_n && !cs_n) lat = ad_out;
      ad_in   = (!cs_n && !rd_n) ? rtc_mem[lat] : 8'hEE;
      leer    = (c == leer2_at);
      ventana = (c >= ven_on && c < ven_off);
      if (done && c >= t_done + 20) break;
    end
    leer = 1'b0; ventana = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, datoRTC, inicioSecuencia, ocupado} !==
        {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got cs%b rd%b wr%b ad%b oe%b out=%h dato=%h ini%b ocu%b want 11100 00 00 0 0",
               cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, datoRTC, inicioSecuencia, ocupado);
    end
    reset = 1'b1; ventana = 1'b1;
    repeat (8) @(negedge clk);
    vectors++;
    if (ocupado !== 1'b0 || cs_n !== 1'b1 || inicioSecuencia !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got ocupado=%b cs_n=%b ini=%b want 0 1 0", ocupado, cs_n, inicioSecuencia);
    end
    ventana = 1'b0;
  endtask

  task automatic test_basic();
    int bad_runs, bad_addr;
    fill_random();
    rtc_mem[8'h21] = 8'h59; rtc_mem[8'h23] = 8'h23; rtc_mem[8'h24] = 8'h12;
    model_update();
    run_seq(0, 1000, -1, 400);
    vectors++;
    if (!done || burst.size() != N_B) begin
      miscompares++;
      $display("FAIL basic_burst_len: got %0d (done=%0d) want %0d", burst.size(), done, N_B);
    end else begin
      for (int k = 0; k < N_B; k++) begin
        vectors++;
        if (burst[k] !== exp_byte(k)) begin
          miscompares++;
          $display("FAIL basic_byte[%0d]: got %0d want %0d", k, burst[k], exp_byte(k));
        end
      end
      vectors++;
      if (burst[4] !== 8'd59 || burst[6] !== 8'd23 || burst[7] !== 8'd12) begin
        miscompares++;
        $display("FAIL basic_known: got %0d %0d %0d want 59 23 12", burst[4], burst[6], burst[7]);
      end
    end
    bad_runs = 0;
    foreach (runs[r]) if (runs[r] != 2 * T_FASE) bad_runs++;
    vectors++;
    if (runs.size() != N_D || bad_runs != 0) begin
      miscompares++;
      $display("FAIL cs_low_runs: got %0d runs, %0d not %0d long, want %0d runs", runs.size(), bad_runs, 2 * T_FASE, N_D);
    end
    bad_addr = 0;
    foreach (addrs[a]) if (a >= N_D || addrs[a] !== tb_dir[a]) bad_addr++;
    vectors++;
    if (addrs.size() != N_D || bad_addr != 0) begin
      miscompares++;
      $display("FAIL addr_order: got %0d addrs, %0d wrong, want %0d", addrs.size(), bad_addr, N_D);
    end
    vectors++;
    if (t_cs0 != 0 || t_ini0 - t_cs0 != T_SEQ + 1 || t_done - t_ini0 != N_B) begin
      miscompares++;
      $display("FAIL seq_timing: got cs0=%0d ini0=%0d done=%0d want 0 %0d %0d", t_cs0, t_ini0, t_done, T_SEQ + 1, T_SEQ + 1 + N_B);
    end
    vectors++;
    if (bad_out != 0) begin
      miscompares++;
      $display("FAIL bus_strobes: got %0d bad cycles want 0", bad_out);
    end
  endtask

  task automatic test_invalid_bcd();
    rtc_mem[8'h22] = 8'h5A;
    model_update();
    run_seq(0, 1000, -1, 400);
    vectors++;
    if (!done || burst.size() != N_B) begin
      miscompares++;
      $display("FAIL invalid_burst_len: got %0d want %0d", burst.size(), N_B);
    end else begin
      vectors++;
      if (burst[5] !== 8'hFF) begin
        miscompares++;
        $display("FAIL invalid_byte5: got %h want ff", burst[5]);
      end
      for (int k = 0; k < N_B; k++) begin
        vectors++;
        if (burst[k] !== exp_byte(k)) begin
          miscompares++;
          $display("FAIL invalid_byte[%0d]: got %0d want %0d", k, burst[k], exp_byte(k));
        end
      end
    end
  endtask

  task automatic test_leer_during_read();
    fill_random();
    model_update();
    run_seq(0, 1000, T_FASE + 1, 400);
    vectors++;
    if (!done || burst.size() != N_B || runs.size() != N_D || restarts != 0 || t_ini0 != T_SEQ + 1) begin
      miscompares++;
      $display("FAIL leer_in_read: got burst=%0d runs=%0d restarts=%0d ini0=%0d want %0d %0d 0 %0d",
               burst.size(), runs.size(), restarts, t_ini0, N_B, N_D, T_SEQ + 1);
    end
  endtask

  task automatic test_reset_mid_addr();
    int activity;
    @(negedge clk); leer = 1'b1;
    @(negedge clk); leer = 1'b0;
    repeat (2 * (2 * T_FASE + 1) + 1) @(negedge clk);
    vectors++;
    if (cs_n !== 1'b0 || ad_oe !== 1'b1 || ad_out !== tb_dir[2]) begin
      miscompares++;
      $display("FAIL third_addr: got cs_n=%b oe=%b out=%h want 0 1 %h", cs_n, ad_oe, ad_out, tb_dir[2]);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({cs_n, rd_n, wr_n, ad_oe, ocupado} !== 5'b11100) begin
      miscompares++;
      $display("FAIL async_release: got cs%b rd%b wr%b oe%b ocu%b want 11100", cs_n, rd_n, wr_n, ad_oe, ocupado);
    end
    for (int j = 0; j < N_D; j++) mdl_buf[j] = 8'h00;
    @(negedge clk); reset = 1'b1; ventana = 1'b1;
    activity = 0;
    repeat (T_SEQ + 30) begin
      @(negedge clk);
      if (!cs_n || inicioSecuencia || ocupado) activity++;
    end
    ventana = 1'b0;
    vectors++;
    if (activity != 0) begin
      miscompares++;
      $display("FAIL no_burst_after_reset: got %0d active cycles want 0", activity);
    end
    model_update();
    run_seq(0, 1000, -1, 400);
    vectors++;
    if (!done || burst.size() != N_B || burst[N_B - 1] !== exp_byte(N_B - 1)) begin
      miscompares++;
      $display("FAIL restart_after_reset: got len=%0d want %0d", burst.size(), N_B);
    end
  endtask

  task automatic test_ventana_late();
    fill_random();
    model_update();
    run_seq(150, 1000, -1, 500);
    vectors++;
    if (t_ini0 != 151 || t_done != 151 + N_B || burst.size() != N_B) begin
      miscompares++;
      $display("FAIL ventana_late: got ini0=%0d done=%0d len=%0d want 151 %0d %0d", t_ini0, t_done, burst.size(), 151 + N_B, N_B);
    end
  endtask

  task automatic test_ventana_drop();
    fill_random();
    model_update();
    run_seq(0, T_SEQ + 1 + 5, -1, 400);
    vectors++;
    if (t_ini0 != T_SEQ + 1 || t_done != T_SEQ + 1 + N_B || burst.size() != N_B || bad_out != 0) begin
      miscompares++;
      $display("FAIL ventana_drop: got ini0=%0d done=%0d len=%0d bad=%0d want %0d %0d %0d 0",
               t_ini0, t_done, burst.size(), bad_out, T_SEQ + 1, T_SEQ + 1 + N_B, N_B);
    end
  endtask

  task automatic test_random();
    int von, exp_ini, nbad;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      model_update();
      von = $urandom_range(0, 140);
      exp_ini = (von + 1 > T_SEQ + 1) ? von + 1 : T_SEQ + 1;
      run_seq(von, 1000, -1, 500);
      nbad = 0;
      for (int k = 0; k < burst.size() && k < N_B; k++) if (burst[k] !== exp_byte(k)) nbad++;
      vectors++;
      if (!done || burst.size() != N_B || nbad != 0 || t_ini0 != exp_ini) begin
        miscompares++;
        $display("FAIL random[%0d]: got len=%0d badbytes=%0d ini0=%0d want %0d 0 %0d", it, burst.size(), nbad, t_ini0, N_B, exp_ini);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rtc_mem[a] = 8'h00;
    for (int j = 0; j < N_D; j++) mdl_buf[j] = 8'h00;
    test_reset();
    test_basic();
    test_invalid_bcd();
    test_leer_during_read();
    test_reset_mid_addr();
    test_ventana_late();
    test_ventana_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lectura_rtc.md
LECTURA_RTC -- requirements
Module: lectura_rtc

Interface
REQ-001 Parameter T_FASE, default 4: clock cycles each RTC bus phase is held.
REQ-002 Parameter N_RELLENO, default 4: zero pad bytes at the head of each output burst.
REQ-003 Parameter N_DATOS, default 11: RTC registers read per sequence.
REQ-004 clk  in  1  system clock; all logic on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; the only reset of the block.
REQ-006 leer  in  1  one-cycle request to start a read sequence.
REQ-007 ventana  in  1  vertical blanking indicator, high while pixely>=480.
REQ-008 ad_in  in  8  RTC multiplexed address/data bus, input side.
REQ-009 ad_out  out  8  RTC bus, output side.
REQ-010 ad_oe  out  1  high = block drives the bus.
REQ-011 cs_n, rd_n, wr_n  out  1 each  active-low RTC strobes.
REQ-012 a_d  out  1  0 = address phase, 1 = data phase.
REQ-013 datoRTC  out  8  binary value streamed to the display interface.
REQ-014 inicioSecuencia  out  1  high on every cycle datoRTC carries a burst byte.
REQ-015 ocupado  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, ADDR, READ, NEXT, WAIT_WIN, STREAM.
REQ-017 IDLE: leer=1 clears the register index i to 0 and moves to ADDR; leer in any other state is ignored.
REQ-018 ADDR, T_FASE cycles: cs_n=0, wr_n=0, rd_n=1, a_d=0, ad_oe=1, ad_out=DIR[i].
REQ-019 READ, T_FASE cycles: cs_n=0, rd_n=0, wr_n=1, a_d=1, ad_oe=0; ad_in is sampled on the last READ cycle only.
REQ-020 NEXT, 1 cycle: all strobes high, ad_oe=0; the converted byte is written to buf[i]; if i=N_DATOS-1 go to WAIT_WIN, else i+1 and go to ADDR.
REQ-021 Register order DIR[0..10]: 0x21 s, 0x22 min, 0x23 h, 0x24 date, 0x25 month, 0x26 year, 0x27 weekday, 0x28 week no., 0x41 timer s, 0x42 timer min, 0x43 timer h.
REQ-022 BCD conversion: byte = 10*hi + lo; if either nibble >9, store 8'hFF.
REQ-023 WAIT_WIN: hold until ventana=1, then go to STREAM.
REQ-024 STREAM, exactly N_RELLENO+N_DATOS cycles: inicioSecuencia=1; burst byte k=0..N_RELLENO-1 is 8'h00; byte N_RELLENO+j is buf[j]; then go to IDLE.
REQ-025 If ventana falls during STREAM, the burst still completes; there is no retransmission.
REQ-026 Outside STREAM: inicioSecuencia=0 and datoRTC=8'h00.
REQ-027 A full sequence takes N_DATOS*(2*T_FASE+1) cycles from ADDR entry to WAIT_WIN.
REQ-028 buf keeps its last contents between sequences.
REQ-029 Every output is registered; no combinational path from any input to any output.

Reset
REQ-030 Asserting reset: state=IDLE, i=0, buf all 8'h00, cs_n=rd_n=wr_n=1, a_d=0, ad_oe=0, ad_out=0, datoRTC=0, inicioSecuencia=0, ocupado=0.
REQ-031 Reset mid-bus-cycle releases the strobes immediately (asynchronously); the partial sequence is discarded.
REQ-032 After reset is released, the block idles until the next leer.

Structure
REQ-033 Shared package rtc_pkg: the DIR table, state encodings, and the N_RELLENO/N_DATOS defaults.
REQ-034 One sub-module, conv_bcd_bin: 8-bit BCD in, 8-bit binary out, 8'hFF on an invalid nibble.
REQ-035 The FSM, phase counter, index counter and buffer stay in lectura_rtc.

Verification
REQ-036 Model RTC returns 0x59 at 0x21, 0x23 at 0x23, 0x12 at 0x24; leer pulse, then ventana=1 -> burst of 15 bytes: 0,0,0,0,59,...,23,12,... in decimal.
REQ-037 ad_in=0x5A at 0x22 -> buf[1]=8'hFF, and byte 5 of the burst is 8'hFF.
REQ-038 T_FASE=4 -> cs_n low exactly 8 cycles per register, and 99 cycles from ADDR entry to WAIT_WIN.
REQ-039 leer pulsed during READ -> no restart; exactly one burst results.
REQ-040 reset asserted during the 3rd ADDR phase -> strobes high the same cycle; no burst until a new leer.
REQ-041 ventana drops after 5 STREAM cycles -> inicioSecuencia stays high for the full 15 cycles, then 0.
